// File: rtl/uart_rx_parity_engine.sv
// uart_rx_parity_engine: frame-level parity checker fed by a UART bit sampler.
// Define UART_RX_PAR_ERR_CNT_EN to add the saturating err_cnt output and counter.
module uart_rx_parity_engine #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PAR_EN,
  input  logic [1:0]       PAR_TYP,
  input  logic             frm_start,
  input  logic             rx_bit,
  input  logic             data_vld,
  input  logic             par_vld,
  input  logic             err_clr,
  output logic             par_done,
  output logic             par_err,
  output logic             seq_err,
  output logic             err_sticky
`ifdef UART_RX_PAR_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DATA     = 2'd1;
  localparam logic [1:0] PAR_WAIT = 2'd2;

  localparam logic [1:0] TYP_EVEN  = 2'b00;
  localparam logic [1:0] TYP_ODD   = 2'b01;
  localparam logic [1:0] TYP_MARK  = 2'b10;
  localparam logic [1:0] TYP_SPACE = 2'b11;

  localparam int              BC_W     = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_W - 1);

  // Marker scope that only elaborates for unsupported parameter values.
  generate
    if (DATA_W < 5 || DATA_W > 9 || CNT_W < 1 || CNT_W > 16) begin : g_param_out_of_range
    end
  endgenerate

  logic [1:0]      state_reg, state_next;
  logic            acc_reg, acc_next;
  logic [BC_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic            cfg_en_reg, cfg_en_next;
  logic [1:0]      cfg_typ_reg, cfg_typ_next;
  logic            done_next, perr_next, serr_next;
  logic            sticky_next;
  logic            err_any;
  logic            exp_par;

  always_comb begin
    exp_par = 1'b0;
    case (cfg_typ_reg)
      TYP_EVEN:  exp_par = acc_reg;
      TYP_ODD:   exp_par = ~acc_reg;
      TYP_MARK:  exp_par = 1'b1;
      TYP_SPACE: exp_par = 1'b0;
      default:   exp_par = 1'b0;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    bit_cnt_next = bit_cnt_reg;
    cfg_en_next  = cfg_en_reg;
    cfg_typ_next = cfg_typ_reg;
    done_next    = 1'b0;
    perr_next    = 1'b0;
    serr_next    = 1'b0;

    if (frm_start) begin
      // A new frame always wins; whatever was in flight is abandoned without a report.
      cfg_en_next  = PAR_EN;
      cfg_typ_next = PAR_TYP;
      acc_next     = 1'b0;
      bit_cnt_next = '0;
      state_next   = DATA;
    end else begin
      case (state_reg)
        DATA: begin
          if (data_vld && par_vld) begin
            serr_next  = 1'b1;
            state_next = IDLE;
          end else if (par_vld) begin
            serr_next  = 1'b1;
            done_next  = 1'b1;
            state_next = IDLE;
          end else if (data_vld) begin
            acc_next     = acc_reg ^ rx_bit;
            bit_cnt_next = bit_cnt_reg + BC_W'(1);
            if (bit_cnt_reg == BIT_LAST) begin
              if (cfg_en_reg) begin
                state_next = PAR_WAIT;
              end else begin
                done_next  = 1'b1;
                state_next = IDLE;
              end
            end
          end
        end
        PAR_WAIT: begin
          if (data_vld && par_vld) begin
            serr_next  = 1'b1;
            state_next = IDLE;
          end else if (data_vld) begin
            serr_next  = 1'b1;
            done_next  = 1'b1;
            state_next = IDLE;
          end else if (par_vld) begin
            done_next  = 1'b1;
            perr_next  = (rx_bit != exp_par);
            state_next = IDLE;
          end
        end
        IDLE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign err_any     = perr_next | serr_next;
  assign sticky_next = err_any | (err_sticky & ~err_clr);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg   <= IDLE;
      acc_reg     <= 1'b0;
      bit_cnt_reg <= '0;
      cfg_en_reg  <= 1'b0;
      cfg_typ_reg <= 2'b00;
      par_done    <= 1'b0;
      par_err     <= 1'b0;
      seq_err     <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      bit_cnt_reg <= bit_cnt_next;
      cfg_en_reg  <= cfg_en_next;
      cfg_typ_reg <= cfg_typ_next;
      par_done    <= done_next;
      par_err     <= perr_next;
      seq_err     <= serr_next;
      err_sticky  <= sticky_next;
    end
  end

`ifdef UART_RX_PAR_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_next;

  // A clear in the same cycle as a new error leaves that one error counted.
  always_comb begin
    err_cnt_next = err_cnt;
    if (err_clr) begin
      err_cnt_next = err_any ? CNT_W'(1) : '0;
    end else if (err_any && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt_next = err_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_cnt <= '0;
    end else begin
      err_cnt <= err_cnt_next;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_parity_engine.sv
// Self-checking bench for uart_rx_parity_engine: vector table, corner sequences, random frames.
module tb_uart_rx_parity_engine;
  localparam int DW = 8;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic          PAR_EN;
  logic [1:0]    PAR_TYP;
  logic          frm_start, rx_bit, data_vld, par_vld, err_clr;
  logic          par_done, par_err, seq_err, err_sticky;
`ifdef UART_RX_PAR_ERR_CNT_EN
  logic [CW-1:0] err_cnt;
`endif

  int   tests = 0;
  int   fails = 0;
  int   done_pulses = 0;
  int   seq_pulses = 0;
  logic sticky_exp = 1'b0;
  int   cnt_exp = 0;

  typedef struct {
    logic          pen;
    logic [1:0]    typ;
    logic [DW-1:0] data;
    logic          pbit;
    logic          exp_err;
  } vec_t;
  vec_t vecs[12];

  always #5 CLK = ~CLK;

  uart_rx_parity_engine #(.DATA_W(DW), .CNT_W(CW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .frm_start (frm_start),
    .rx_bit    (rx_bit),
    .data_vld  (data_vld),
    .par_vld   (par_vld),
    .err_clr   (err_clr),
    .par_done  (par_done),
    .par_err   (par_err),
    .seq_err   (seq_err),
`ifdef UART_RX_PAR_ERR_CNT_EN
    .err_sticky(err_sticky),
    .err_cnt   (err_cnt)
`else
    .err_sticky(err_sticky)
`endif
  );

  // Pulse counters: a pulse wider than one cycle counts more than once.
  always @(negedge CLK) begin
    if (par_done) done_pulses++;
    if (seq_err) seq_pulses++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic model_par(input logic [1:0] typ, input logic [DW-1:0] d);
    int ones;
    ones = $countones(d);
    case (typ)
      2'b00:   return (ones % 2) == 1;
      2'b01:   return (ones % 2) == 0;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void note_err(input logic e, input logic clr);
    if (e) sticky_exp = 1'b1;
    else if (clr) sticky_exp = 1'b0;
    if (clr) cnt_exp = e ? 1 : 0;
    else if (e && cnt_exp < CNT_MAX) cnt_exp++;
  endfunction

  task automatic check_out(input string tag, input logic d, input logic e, input logic s);
    check({tag, ".par_done"}, 32'(par_done), 32'(d));
    check({tag, ".par_err"}, 32'(par_err), 32'(e));
    check({tag, ".seq_err"}, 32'(seq_err), 32'(s));
    check({tag, ".err_sticky"}, 32'(err_sticky), 32'(sticky_exp));
`ifdef UART_RX_PAR_ERR_CNT_EN
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(cnt_exp));
`endif
  endtask

  task automatic strobe(input logic fs, input logic dv, input logic pv, input logic b, input logic clr);
    frm_start = fs; data_vld = dv; par_vld = pv; rx_bit = b; err_clr = clr;
    @(posedge CLK); #1;
    frm_start = 1'b0; data_vld = 1'b0; par_vld = 1'b0; err_clr = 1'b0;
    rx_bit = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) strobe(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // fault: 0 clean, 1 par_vld after k data bits, 2 data_vld in parity slot, 3 both strobes after k bits
  task automatic run_frame(input logic pen, input logic [1:0] typ, input logic [DW-1:0] data,
                           input logic pbit, input int fault, input int k, input int gap,
                           input logic exp_err, input logic clr, input string tag);
    int   d0, s0, nbits;
    logic exp_done, exp_seq, last_is_data;
    exp_done     = (fault != 3);
    exp_seq      = (fault != 0);
    nbits        = (fault == 1 || fault == 3) ? k : DW;
    last_is_data = (fault == 0) && !pen;
    d0 = done_pulses;
    s0 = seq_pulses;
    PAR_EN = pen;
    PAR_TYP = typ;
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      PAR_EN = 1'($urandom_range(0, 1));
      PAR_TYP = 2'($urandom_range(0, 3));
      idle($urandom_range(0, gap));
      strobe(1'b0, 1'b1, 1'b0, data[i], (last_is_data && i == DW - 1) ? clr : 1'b0);
    end
    if (!last_is_data) begin
      check({tag, ".early_done"}, 32'(par_done), 32'd0);
      case (fault)
        2:       strobe(1'b0, 1'b1, 1'b0, pbit, clr);
        3:       strobe(1'b0, 1'b1, 1'b1, pbit, clr);
        default: strobe(1'b0, 1'b0, 1'b1, pbit, clr);
      endcase
    end
    note_err(exp_err || exp_seq, clr);
    check_out(tag, exp_done, exp_err, exp_seq);
    $display("[TB] %s pen=%0d typ=%0d data=%02h pbit=%0d fault=%0d k=%0d clr=%0d -> done=%0d err=%0d seq=%0d sticky=%0d",
             tag, pen, typ, data, pbit, fault, k, clr, par_done, par_err, seq_err, err_sticky);
    idle(1);
    check({tag, ".done_pulses"}, 32'(done_pulses - d0), 32'(exp_done));
    check({tag, ".seq_pulses"}, 32'(seq_pulses - s0), 32'(exp_seq));
  endtask

  initial begin
    int            d0, s0, fault, k;
    logic          pen, pbit, clr, e;
    logic [1:0]    typ;
    logic [DW-1:0] data;

    vecs[0]  = '{1'b1, 2'b00, 8'hA5, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2'b00, 8'hA5, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 2'b01, 8'hA5, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 2'b01, 8'hA5, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 2'b10, 8'h3C, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 2'b10, 8'h3C, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 2'b11, 8'hA5, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 2'b11, 8'hFF, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 2'b00, 8'hA5, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 2'b10, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 2'b00, 8'h07, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 2'b01, 8'hFF, 1'b1, 1'b0};

    RST = 1'b1; PAR_EN = 1'b0; PAR_TYP = 2'b00;
    frm_start = 1'b0; rx_bit = 1'b0; data_vld = 1'b0; par_vld = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_out("reset", 1'b0, 1'b0, 1'b0);
    #3 RST = 1'b0;

    // Strobes before any frm_start are ignored.
    d0 = done_pulses; s0 = seq_pulses;
    strobe(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    strobe(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    strobe(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    check("idle_ignore.done", 32'(done_pulses - d0), 32'd0);
    check("idle_ignore.seq", 32'(seq_pulses - s0), 32'd0);
    $display("[TB] idle strobes after reset: done_pulses=%0d seq_pulses=%0d", done_pulses - d0, seq_pulses - s0);

    for (int i = 0; i < 12; i++)
      run_frame(vecs[i].pen, vecs[i].typ, vecs[i].data, vecs[i].pbit, 0, 0, 1,
                vecs[i].exp_err, 1'b0, $sformatf("vec%0d", i));

    // par_vld after 5 data bits, then stray strobes must be ignored.
    run_frame(1'b1, 2'b00, 8'hA5, 1'b0, 1, 5, 0, 1'b0, 1'b0, "early_par");
    d0 = done_pulses; s0 = seq_pulses;
    strobe(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    strobe(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);
    check("after_seq.done", 32'(done_pulses - d0), 32'd0);
    check("after_seq.seq", 32'(seq_pulses - s0), 32'd0);

    // Restart after 4 bits drops the partial frame silently.
    d0 = done_pulses; s0 = seq_pulses;
    PAR_EN = 1'b1; PAR_TYP = 2'b00;
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_frame(1'b1, 2'b00, 8'hA5, 1'b0, 0, 0, 0, 1'b0, 1'b0, "restart");
    check("restart.total_done", 32'(done_pulses - d0), 32'd1);
    check("restart.total_seq", 32'(seq_pulses - s0), 32'd0);

    // frm_start with data_vld/par_vld in the same cycle: the strobes do not count.
    PAR_EN = 1'b1; PAR_TYP = 2'b00;
    data = 8'hA5;
    strobe(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("prio.seq", 32'(seq_err), 32'd0);
    for (int i = 0; i < DW; i++) strobe(1'b0, 1'b1, 1'b0, data[i], 1'b0);
    check("prio.eighth_bit_seq", 32'(seq_err), 32'd0);
    check("prio.eighth_bit_done", 32'(par_done), 32'd0);
    strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    note_err(1'b0, 1'b0);
    check_out("prio", 1'b1, 1'b0, 1'b0);
    $display("[TB] prio frame done=%0d err=%0d seq=%0d", par_done, par_err, seq_err);

    // Async reset while outputs are high clears everything without a clock edge.
    PAR_EN = 1'b1; PAR_TYP = 2'b10;
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DW; i++) strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    note_err(1'b1, 1'b0);
    check_out("pre_rst", 1'b1, 1'b1, 1'b0);
    #2 RST = 1'b1;
    #1;
    sticky_exp = 1'b0; cnt_exp = 0;
    check_out("async_rst", 1'b0, 1'b0, 1'b0);
    $display("[TB] async reset: done=%0d err=%0d seq=%0d sticky=%0d", par_done, par_err, seq_err, err_sticky);
    #2 RST = 1'b0;

    // Reset mid-frame: the rest of that frame must produce nothing.
    PAR_EN = 1'b1; PAR_TYP = 2'b00;
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) strobe(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    #3 RST = 1'b1;
    #1 check_out("mid_rst", 1'b0, 1'b0, 1'b0);
    #2 RST = 1'b0;
    d0 = done_pulses; s0 = seq_pulses;
    for (int i = 0; i < 5; i++) strobe(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    strobe(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);
    check("mid_rst.done", 32'(done_pulses - d0), 32'd0);
    check("mid_rst.seq", 32'(seq_pulses - s0), 32'd0);
    $display("[TB] mid-frame reset: done_pulses=%0d seq_pulses=%0d", done_pulses - d0, seq_pulses - s0);

    // Five mark-parity errors, then a sixth coincident with err_clr.
    strobe(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    note_err(1'b0, 1'b1);
    check("clr.sticky", 32'(err_sticky), 32'd0);
    for (int i = 0; i < 5; i++)
      run_frame(1'b1, 2'b10, DW'($urandom), 1'b0, 0, 0, 0, 1'b1, 1'b0, $sformatf("cnt_err%0d", i));
`ifdef UART_RX_PAR_ERR_CNT_EN
    check("cnt_saturated", 32'(err_cnt), 32'd3);
`endif
    run_frame(1'b1, 2'b10, 8'h5A, 1'b0, 0, 0, 0, 1'b1, 1'b1, "err_with_clr");
    check("err_with_clr.sticky_kept", 32'(err_sticky), 32'd1);
`ifdef UART_RX_PAR_ERR_CNT_EN
    check("err_with_clr.cnt_one", 32'(err_cnt), 32'd1);
`endif

    // Random frames against the frame-level model.
    for (int n = 0; n < 60; n++) begin
      pen   = 1'($urandom_range(0, 1));
      typ   = 2'($urandom_range(0, 3));
      data  = DW'($urandom);
      pbit  = 1'($urandom_range(0, 1));
      fault = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      if (fault == 2 && !pen) fault = 1;
      k     = int'($urandom_range(0, DW - 1));
      clr   = ($urandom_range(0, 4) == 0);
      e     = (fault == 0 && pen) ? (pbit != model_par(typ, data)) : 1'b0;
      run_frame(pen, typ, data, pbit, fault, k, 2, e, clr, $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_parity_engine.md
UART_RX_PARITY_ENGINE -- requirements
Module: uart_rx_parity_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (legal range 5..9).
REQ-002 SHALL have parameter CNT_W, default 8, error-counter width (legal range 1..16).
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port PAR_EN  input  1  1 = frame carries a parity bit.
REQ-006 SHALL have port PAR_TYP  input  2  00 even, 01 odd, 10 mark, 11 space.
REQ-007 SHALL have port frm_start  input  1  start-of-frame strobe, one cycle.
REQ-008 SHALL have port rx_bit  input  1  sampled serial bit, qualified by data_vld or par_vld.
REQ-009 SHALL have port data_vld  input  1  rx_bit is the next data bit, LSB first.
REQ-010 SHALL have port par_vld  input  1  rx_bit is the parity bit.
REQ-011 SHALL have port err_clr  input  1  clears err_sticky and err_cnt.
REQ-012 SHALL have port par_done  output  1  one-cycle pulse: frame check finished.
REQ-013 SHALL have port par_err  output  1  parity mismatch; valid only while par_done=1.
REQ-014 SHALL have port seq_err  output  1  one-cycle pulse: strobe order violated.
REQ-015 SHALL have port err_sticky  output  1  latched OR of all par_err/seq_err pulses.
REQ-016 SHALL have port err_cnt  output  CNT_W  saturating error count; present only with the macro.

Function
REQ-017 SHALL implement FSM states IDLE, DATA, PAR_WAIT.
REQ-018 SHALL, on frm_start in any state: register PAR_EN/PAR_TYP into frame config, clear accumulator and bit counter, enter DATA; any in-progress frame is dropped silently.
REQ-019 SHALL give frm_start priority over data_vld/par_vld in the same cycle; those strobes are ignored.
REQ-020 SHALL ignore data_vld and par_vld in IDLE.
REQ-021 SHALL, in DATA on data_vld, XOR rx_bit into the accumulator and increment the bit counter.
REQ-022 SHALL, on the DATA_W-th data_vld: enter PAR_WAIT if frame PAR_EN=1; otherwise enter IDLE and pulse par_done with par_err=0.
REQ-023 SHALL compute expected parity as: even = accumulator, odd = ~accumulator, mark = 1, space = 0.
REQ-024 SHALL, in PAR_WAIT on par_vld, pulse par_done with par_err = (rx_bit != expected), then enter IDLE.
REQ-025 SHALL, on par_vld in DATA, or data_vld in PAR_WAIT, pulse seq_err and par_done with par_err=0, then enter IDLE.
REQ-026 SHALL ignore simultaneous data_vld and par_vld in DATA or PAR_WAIT except for pulsing seq_err, then enter IDLE.
REQ-027 SHALL register all outputs; par_done/par_err/seq_err assert on the cycle after the qualifying strobe and last exactly one cycle; par_err is 0 whenever par_done is 0.
REQ-028 SHALL set err_sticky on any par_err or seq_err pulse and clear it on err_clr; set wins when both occur in the same cycle.
REQ-029 SHALL ignore PAR_EN/PAR_TYP changes during a frame.

Reset
REQ-030 SHALL, while RST=1, force state IDLE, accumulator 0, bit counter 0, frame config 0, and par_done, par_err, seq_err, err_sticky, err_cnt to 0, independent of CLK.
REQ-031 SHALL, after RST deassertion, ignore strobes until the next frm_start.

Configuration
REQ-032 SHALL, with UART_RX_PAR_ERR_CNT_EN defined, include err_cnt: +1 per par_err or seq_err pulse, saturates at all-ones, cleared to 0 by err_clr; an error coincident with err_clr gives 1.
REQ-033 SHALL, without UART_RX_PAR_ERR_CNT_EN, omit the err_cnt port and counter logic; all other behaviour is unchanged.

Verification
REQ-034 SHALL cover: DATA_W=8, even, data 0xA5, parity 0 -> par_done=1, par_err=0 one cycle after par_vld; parity 1 -> par_err=1, err_sticky=1.
REQ-035 SHALL cover: odd, 0xA5, parity 1 -> par_err=0; mark, any data, parity 0 -> par_err=1; space, parity 0 -> par_err=0; PAR_EN=0 -> par_done one cycle after the 8th data_vld with par_err=0.
REQ-036 SHALL cover: par_vld after 5 data bits -> seq_err=1, par_done=1, par_err=0, state IDLE; following data_vld ignored.
REQ-037 SHALL cover: frm_start after 4 bits, then a clean 0xA5 even frame -> par_err=0, no seq_err; RST pulsed mid-frame -> all outputs 0 at once, no par_done.
REQ-038 SHALL cover, with macro and CNT_W=2: 5 parity errors -> err_cnt=3; err_clr coincident with a 6th error -> err_cnt=1, err_sticky=1.
